// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_conditioner_pkg
// Shared constants and helpers for the input conditioner slice.
//   DEF_N_CH            default number of button/switch channels
//   DEF_SYNC_STAGES     default synchronizer depth
//   DEF_DEBOUNCE_CYCLES default stable-cycle count needed to accept a level
//   cnt_width()         width of a debounce counter able to hold DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------
package input_conditioner_pkg;

    localparam int DEF_N_CH            = 5;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;

    // Counter width for a debounce count of 'cycles'. Never narrower than one
    // bit so that DEBOUNCE_CYCLES = 1 still yields a legal vector.
    function automatic int cnt_width(input int cycles);
        int w;
        if (cycles < 1) begin
            w = 1;
        end else begin
            w = $clog2(cycles + 1);
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : input_conditioner_pkg

// File: rtl/input_conditioner_if.sv
// -----------------------------------------------------------------------------
// input_conditioner_if
// Bundles the per-channel button/switch signals of the input conditioner.
//   raw_in     [N_CH] asynchronous button/switch levels
//   toggle_clr        synchronous clear of every toggle-mode channel
//   level      [N_CH] conditioned level per channel
//   rise       [N_CH] one-cycle pulse on accepted 0->1 transition
//   fall       [N_CH] one-cycle pulse on accepted 1->0 transition
// Modports:
//   master - the side that owns the buttons and consumes conditioned levels
//   slave  - the conditioner itself
// -----------------------------------------------------------------------------
interface input_conditioner_if
    import input_conditioner_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);

    logic [N_CH-1:0] raw_in;
    logic            toggle_clr;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    modport master (
        output raw_in,
        output toggle_clr,
        input  level,
        input  rise,
        input  fall
    );

    modport slave (
        input  raw_in,
        input  toggle_clr,
        output level,
        output rise,
        output fall
    );

endinterface : input_conditioner_if

// File: rtl/input_conditioner_debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One conditioner channel: synchronizer chain, debounce counter, accepted
// (stable) level and registered edge pulses.
//   clock   system clock, rising edge
//   reset   asynchronous active-low reset
//   raw     asynchronous button/switch level
//   stable  debounced level
//   rise    one-cycle pulse in the cycle stable first shows 1
//   fall    one-cycle pulse in the cycle stable first shows 0
// Latency from the first edge that samples a clean change of raw to stable
// changing is SYNC_STAGES + DEBOUNCE_CYCLES edges.
// -----------------------------------------------------------------------------
module debounce_ch
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync;

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          stable_reg;
    logic          stable_next;
    logic          rise_reg;
    logic          rise_next;
    logic          fall_reg;
    logic          fall_next;

    // Synchronizer: bit 0 samples the asynchronous input, only the last
    // stage is used by the debounce logic.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_reg[SYNC_STAGES-1];

    // The counter tracks how many consecutive edges sync has disagreed with
    // stable. Any agreement (including a bounce back) clears it, and the
    // counter never passes CNT_MAX because acceptance clears it on that edge.
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        if (sync == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_next    = '0;
            stable_next = sync;
            rise_next   = sync;
            fall_next   = ~sync;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
        end
    end

    assign stable = stable_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;

endmodule : debounce_ch

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Synchronizes and debounces N_CH button/switch inputs and produces a
// conditioned level plus one-cycle rise/fall pulses per channel. Channels
// selected by TOGGLE_MASK present a toggle state on level instead of the
// debounced level: it flips once per accepted press and starts at 0.
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    input_conditioner_if.slave
//            raw_in, toggle_clr  -> in
//            level, rise, fall   <- out
// -----------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int              N_CH            = DEF_N_CH,
    parameter int              SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int              DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [N_CH-1:0] TOGGLE_MASK     = '0
) (
    input  logic                clock,
    input  logic                reset,
    input_conditioner_if.slave  bus
);

    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] fall_w;
    logic [N_CH-1:0] toggle_reg;
    logic [N_CH-1:0] toggle_next;
    logic [N_CH-1:0] level_w;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_ch #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock  (clock),
                .reset  (reset),
                .raw    (bus.raw_in[gi]),
                .stable (stable[gi]),
                .rise   (rise_w[gi]),
                .fall   (fall_w[gi])
            );

            // Toggle state updates on the edge after a rise pulse; a clear
            // wins over a coincident rise. Channels outside TOGGLE_MASK keep
            // the flop but never select it, so it is pruned in synthesis.
            always_comb begin
                toggle_next[gi] = toggle_reg[gi];
                if (bus.toggle_clr) begin
                    toggle_next[gi] = 1'b0;
                end else if (rise_w[gi]) begin
                    toggle_next[gi] = ~toggle_reg[gi];
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    toggle_reg[gi] <= 1'b0;
                end else begin
                    toggle_reg[gi] <= toggle_next[gi];
                end
            end

            assign level_w[gi] = TOGGLE_MASK[gi] ? toggle_reg[gi] : stable[gi];
        end
    endgenerate

    assign bus.level = level_w;
    assign bus.rise  = rise_w;
    assign bus.fall  = fall_w;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Self-checking bench for input_conditioner with N_CH=5, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, TOGGLE_MASK=5'b00001. Inputs change 1 time unit after
// a rising edge; outputs are checked 1 time unit after the following edge.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int N = 5;

    logic clock = 1'b0;
    logic reset;

    input_conditioner_if #(.N_CH(N)) bus ();

    input_conditioner #(
        .N_CH            (N),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .TOGGLE_MASK     (5'b00001)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] raw;
        logic         clr;
        logic [N-1:0] lvl;
        logic [N-1:0] rs;
        logic [N-1:0] fl;
        string        name;
    } vec_t;

    typedef struct {
        logic [N-1:0] lvl;
        logic [N-1:0] rs;
        logic [N-1:0] fl;
        string        name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int row    = 0;

    task automatic check_out(input string name, input logic [N-1:0] l,
                             input logic [N-1:0] r, input logic [N-1:0] f);
        checks++;
        if (bus.level !== l || bus.rise !== r || bus.fall !== f) begin
            errors++;
            $display("FAIL %s row %0d: got level=%b rise=%b fall=%b, want level=%b rise=%b fall=%b",
                     name, row, bus.level, bus.rise, bus.fall, l, r, f);
        end else begin
            $display("ok   %s row %0d: level=%b rise=%b fall=%b",
                     name, row, bus.level, bus.rise, bus.fall);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare the
    // outputs seen after the next rising edge.
    task automatic step(input string name, input logic [N-1:0] raw, input logic clr,
                        input logic [N-1:0] l, input logic [N-1:0] r, input logic [N-1:0] f);
        exp_t e;
        bus.raw_in     = raw;
        bus.toggle_clr = clr;
        e.lvl  = l;
        e.rs   = r;
        e.fl   = f;
        e.name = name;
        sb.push_back(e);
        @(posedge clock);
        #1;
        row++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty row %0d", row);
        end else begin
            e = sb.pop_front();
            check_out(e.name, e.lvl, e.rs, e.fl);
        end
    endtask

    task automatic add(input string name, input logic [N-1:0] raw, input logic clr,
                       input logic [N-1:0] l, input logic [N-1:0] r,
                       input logic [N-1:0] f, input int n);
        vec_t v;
        v.raw = raw; v.clr = clr; v.lvl = l; v.rs = r; v.fl = f; v.name = name;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        // ---- vector table: each row is one clock of stimulus ----
        // single channel press/release, latency 6 edges, clr ignored on normal channel
        add("ch2_press",   5'b00100, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5);
        add("ch2_rise",    5'b00100, 1'b0, 5'b00100, 5'b00100, 5'b00000, 1);
        add("ch2_hold",    5'b00100, 1'b1, 5'b00100, 5'b00000, 5'b00000, 1);
        add("ch2_release", 5'b00000, 1'b0, 5'b00100, 5'b00000, 5'b00000, 5);
        add("ch2_fall",    5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00100, 1);
        add("ch2_idle",    5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1);
        // 3-cycle glitch is rejected
        add("ch3_glitch",  5'b01000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3);
        add("ch3_after",   5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5);
        // toggle channel 0: press 1
        add("ch0_p1",      5'b00001, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5);
        add("ch0_p1_rise", 5'b00001, 1'b0, 5'b00000, 5'b00001, 5'b00000, 1);
        add("ch0_p1_tog",  5'b00001, 1'b0, 5'b00001, 5'b00000, 5'b00000, 1);
        add("ch0_r1",      5'b00000, 1'b0, 5'b00001, 5'b00000, 5'b00000, 5);
        add("ch0_r1_fall", 5'b00000, 1'b0, 5'b00001, 5'b00000, 5'b00001, 1);
        add("ch0_r1_idle", 5'b00000, 1'b0, 5'b00001, 5'b00000, 5'b00000, 1);
        // press 2 toggles back to 0
        add("ch0_p2",      5'b00001, 1'b0, 5'b00001, 5'b00000, 5'b00000, 5);
        add("ch0_p2_rise", 5'b00001, 1'b0, 5'b00001, 5'b00001, 5'b00000, 1);
        add("ch0_p2_tog",  5'b00001, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1);
        add("ch0_r2",      5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5);
        add("ch0_r2_fall", 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00001, 1);
        add("ch0_r2_idle", 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1);
        // press 3 with toggle_clr coincident with the rise: level stays 0
        add("ch0_p3",      5'b00001, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5);
        add("ch0_p3_rise", 5'b00001, 1'b0, 5'b00000, 5'b00001, 5'b00000, 1);
        add("ch0_p3_clr",  5'b00001, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1);
        add("ch0_p3_hold", 5'b00001, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1);
        add("ch0_r3",      5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5);
        add("ch0_r3_fall", 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00001, 1);
        add("ch0_r3_idle", 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1);
        // simultaneous channels
        add("multi_press", 5'b01110, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5);
        add("multi_rise",  5'b01110, 1'b0, 5'b01110, 5'b01110, 5'b00000, 1);
        add("multi_hold",  5'b01110, 1'b0, 5'b01110, 5'b00000, 5'b00000, 1);
        add("multi_rel",   5'b00000, 1'b0, 5'b01110, 5'b00000, 5'b00000, 5);
        add("multi_fall",  5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b01110, 1);
        add("multi_idle",  5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1);
        // bounce 1,0,1,1,1,1 on ch4: accepted only after the last 4 highs
        add("ch4_b1",      5'b10000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1);
        add("ch4_b0",      5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1);
        add("ch4_high",    5'b10000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5);
        add("ch4_rise",    5'b10000, 1'b0, 5'b10000, 5'b10000, 5'b00000, 1);
        add("ch4_hold",    5'b10000, 1'b0, 5'b10000, 5'b00000, 5'b00000, 2);
        add("ch4_rel",     5'b00000, 1'b0, 5'b10000, 5'b00000, 5'b00000, 5);
        add("ch4_fall",    5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b10000, 1);
        add("ch4_idle",    5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1);

        // ---- reset ----
        bus.raw_in     = '0;
        bus.toggle_clr = 1'b0;
        reset          = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_out("reset_state", 5'b00000, 5'b00000, 5'b00000);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // ---- table ----
        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].raw, vecs[i].clr, vecs[i].lvl, vecs[i].rs, vecs[i].fl);
        end

        // ---- all inputs high through reset release ----
        bus.raw_in = 5'b11111;
        reset      = 1'b0;
        #1;
        check_out("rst_all_hi", 5'b00000, 5'b00000, 5'b00000);
        @(posedge clock);
        #1;
        check_out("rst_all_hi_held", 5'b00000, 5'b00000, 5'b00000);
        reset = 1'b1;
        for (int i = 0; i < 5; i++)
            step("rel_wait", 5'b11111, 1'b0, 5'b00000, 5'b00000, 5'b00000);
        step("rel_rise", 5'b11111, 1'b0, 5'b11110, 5'b11111, 5'b00000);
        step("rel_tog",  5'b11111, 1'b0, 5'b11111, 5'b00000, 5'b00000);

        // ---- reset in the middle of a ch1 debounce ----
        for (int i = 0; i < 4; i++)
            step("ch1_partial", 5'b11101, 1'b0, 5'b11111, 5'b00000, 5'b00000);
        #3;
        reset = 1'b0;
        #1;
        check_out("mid_reset_async", 5'b00000, 5'b00000, 5'b00000);
        @(posedge clock);
        #1;
        check_out("mid_reset_held", 5'b00000, 5'b00000, 5'b00000);
        reset = 1'b1;
        for (int i = 0; i < 5; i++)
            step("restart_wait", 5'b11101, 1'b0, 5'b00000, 5'b00000, 5'b00000);
        step("restart_rise", 5'b11101, 1'b0, 5'b11100, 5'b11101, 5'b00000);
        step("restart_tog",  5'b11101, 1'b0, 5'b11101, 5'b00000, 5'b00000);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_input_conditioner
